// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register and delayed-branch next-PC selection.
// Latency: 1 cycle from imem_addr to inst with a zero-wait memory; each wait cycle with nostall=1 inserts one bubble.
// Backpressure: nostall=0 freezes IF/ID; a word arriving under stall parks in ibuf (HOLD) without re-fetching.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [31:0] dpc4,
    output logic        dvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] ibuf;
    logic        rd_valid;
    logic [31:0] rd_pc;

    logic [31:0] target;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic        branch;
    logic        pc_upd;

    always_comb begin
        target = 32'h0;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = jrpc;
            2'b11:   target = jpc;
            default: target = 32'h0;
        endcase
    end

    // A bubble in decode carries no control flow, so pcsource only counts with dvalid.
    assign branch = dvalid && (pcsource != 2'b00);
    assign pc4    = pc + 32'd4;
    assign npc    = branch ? target : (rd_valid ? rd_pc : pc4);
    assign pc_upd = nostall && ((state == HOLD) || imem_ready);

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            inst     <= 32'h0;
            dpc4     <= 32'h0;
            dvalid   <= 1'b0;
            ibuf     <= 32'h0;
            rd_valid <= 1'b0;
            rd_pc    <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        if (nostall) begin
                            inst   <= imem_rdata;
                            dpc4   <= pc4;
                            dvalid <= 1'b1;
                        end else begin
                            ibuf  <= imem_rdata;
                            state <= HOLD;
                        end
                    end else if (nostall) begin
                        inst   <= 32'h0;
                        dvalid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (nostall) begin
                        inst   <= ibuf;
                        dpc4   <= pc4;
                        dvalid <= 1'b1;
                        state  <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase

            // A branch leaving decode before its delay slot is fetched must remember its target.
            if (pc_upd) begin
                pc       <= npc;
                rd_valid <= 1'b0;
            end else if (branch && nostall) begin
                rd_valid <= 1'b1;
                rd_pc    <= target;
            end
        end
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. It feeds the decode stage and its control unit, and consumes that unit's `pcsource` and `nostall` outputs. The stage holds the PC and drives a variable-latency instruction-memory request/ready handshake. It selects the next PC with MIPS delayed-branch semantics: no flush, and the delay slot always executes. It presents `inst`, `dpc4` and a valid flag to decode, inserting bubbles while memory is busy.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `nostall` in 1: from the control unit. 1 = the decode instruction advances this cycle. 0 = decode holds.
- `pcsource` in 2: from the control unit. 00 = pc+4, 01 = `bpc`, 10 = `jrpc`, 11 = `jpc`.
- `bpc` in 32: branch target from decode.
- `jrpc` in 32: register jump target (rs value, forwarded) from decode.
- `jpc` in 32: jump target {pc4[31:28], addr, 00} from decode.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; equals `pc`.
- `imem_ready` in 1: memory has data this cycle.
- `imem_rdata` in 32: instruction; valid only while `imem_ready`=1.
- `pc` out 32: current fetch PC.
- `inst` out 32: IF/ID instruction.
- `dpc4` out 32: IF/ID pc+4.
- `dvalid` out 1: IF/ID holds a real instruction. 0 = bubble, with `inst`=0 (sll $0,$0,0).

## Operation
- **Clock and reset.** Single clock domain. Reset is asynchronous and active-high.
- **States.** FETCH and HOLD. Reset enters FETCH.
- **`imem_req`.** Equals 1 exactly in FETCH, combinational from state.
- **`imem_addr`.** Equals `pc` and is stable while `imem_req`=1 and `imem_ready`=0.
- **Next PC (`npc`).**
  - If `dvalid` & `pcsource`≠00: the selected target.
  - Else if `rd_valid`: `rd_pc`.
  - Else: `pc`+4.
  - All arithmetic is mod 2^32; the wrap from FFFF_FFFC to 0 is legal.
- **Redirect latch.** Registers `rd_valid`/`rd_pc`, internal.
  - Set condition: `dvalid` & `nostall` & `pcsource`≠00, with no PC update in the same cycle. This means the branch leaves decode before its delay slot has been fetched.
  - On set: load `rd_pc` with the selected target.
  - Clear condition: any PC update.
- **FETCH with `imem_ready`=1 and `nostall`=1.** `inst`<=`imem_rdata`, `dpc4`<=`pc`+4, `dvalid`<=1, `pc`<=`npc`. Stay in FETCH.
- **FETCH with `imem_ready`=1 and `nostall`=0.** `ibuf`<=`imem_rdata`. `pc` is unchanged. Go to HOLD. The IF/ID register holds.
- **FETCH with `imem_ready`=0 and `nostall`=1.** Bubble: `inst`<=0, `dvalid`<=0. `dpc4` is unchanged.
- **FETCH with `imem_ready`=0 and `nostall`=0.** IF/ID holds.
- **HOLD with `nostall`=1.** `inst`<=`ibuf`, `dpc4`<=`pc`+4, `dvalid`<=1, `pc`<=`npc`. Go to FETCH.
- **HOLD with `nostall`=0.** Remain in HOLD. No memory request is made and there is no re-fetch.
- **`pcsource` when `dvalid`=0.** Ignored; a bubble decodes to pcsource 00 in any case.
- **Simultaneous branch and delay-slot completion.** If a branch is in decode in the same cycle its delay slot completes, `pc` takes the target directly and no latch is used.

## Timing
- **Reset values.**
  - `pc`=`RESET_PC`, `inst`=0, `dpc4`=0, `dvalid`=0.
  - `rd_valid`=0, `rd_pc`=0, `ibuf`=0.
  - State FETCH, so `imem_req`=1 and `imem_addr`=`RESET_PC` while reset is asserted and after release.
- **Zero-wait memory.** With `imem_ready` tied high, throughput is 1 instruction/cycle. Latency is 1 cycle from the address on `imem_addr` to the instruction on `inst`.
- **Wait states.** Each wait cycle with `nostall`=1 inserts one bubble into decode.
- **Memory sampling.** `imem_ready` and `imem_rdata` are sampled at the rising edge. A new request is issued the cycle after a completed fetch; back-to-back requests are allowed.
- **Reset mid-operation.** Reset during a pending fetch or in HOLD abandons the access and discards `ibuf` and any latched redirect. The memory must tolerate a dropped request.
- **Stall and branch together.** `nostall`=0 with `pcsource`≠00 has no effect on `pc` or the latch. The branch re-presents `pcsource` when it advances.

## Test plan
- **Reset.** Assert `rst` mid-cycle with `imem_ready`=0 → immediately `pc`=0, `inst`=0, `dvalid`=0, `imem_req`=1, `imem_addr`=0. After release, the first completed fetch returns 0x0.
- **Streaming.** `imem_ready`=1, `imem_rdata`=addr|0x2000_0000, `nostall`=1 → `inst` is 0x2000_0000, 0x2000_0004, 0x2000_0008 on consecutive cycles, with `dpc4`=4, 8, 0xC and `dvalid`=1.
- **Wait states.** `imem_ready` is held low for 3 cycles at addr 0x8 → `imem_addr` stays 0x8, decode sees 3 bubbles (`inst`=0, `dvalid`=0), then the 0x8 instruction arrives.
- **Stall on arrival.**
  - Stimulus: `nostall`=0 during the cycle `imem_ready`=1 at 0xC, then `nostall` held low 2 more cycles.
  - Required: HOLD is entered, `imem_req`=0 for 3 cycles and IF/ID holds.
  - Then when `nostall`=1: `inst` becomes the 0xC word, and the next request is to 0x10 only (single access to 0xC).
- **Slow delay slot.**
  - Stimulus: branch at 0x4 in decode with `pcsource`=01 and `bpc`=0x100, while the fetch at 0x8 waits 2 cycles.
  - Required: the redirect is latched and the branch leaves decode. When the 0x8 word arrives, `pc` becomes 0x100 and the next `imem_addr` is 0x100.
- **Immediate jump.** A jr in decode with `pcsource`=10 and `jrpc`=0x40 in the same cycle the delay slot completes → next `imem_addr`=0x40, `rd_valid` stays 0.
